load_store_unit: RTL

//  Sits directly upstream of the data memory. Takes byte-addressed load/store requests

---
 rtl/load_store_unit_pkg.sv | 29 ++
 rtl/load_store_unit_lane_align.sv | 38 +++
 rtl/load_store_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared encodings, request payload and legality helper for the load/store unit.
package load_store_unit_pkg;

  localparam int unsigned DATA_W        = 32;
  localparam int unsigned DEPTH_DEFAULT = 256;

  localparam logic [1:0] SIZE_BYTE    = 2'd0;
  localparam logic [1:0] SIZE_HALF    = 2'd1;
  localparam logic [1:0] SIZE_WORD    = 2'd2;
  localparam logic [1:0] SIZE_ILLEGAL = 2'd3;

  typedef struct packed {
    logic [1:0]        size;
    logic              uns;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } lsu_req_t;

  // True when the request must be rejected without touching memory.
  function automatic logic req_illegal(input logic [DATA_W-1:0] addr,
                                       input logic [1:0] size,
                                       input int unsigned depth);
    logic bad_align;
    bad_align = ((size == SIZE_HALF) && addr[0]) ||
                ((size == SIZE_WORD) && (addr[1:0] != 2'b00));
    return (size == SIZE_ILLEGAL) || bad_align || (32'(addr[31:2]) >= depth);
  endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Little-endian lane handling: load extract/extend and store merge into an old word.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [DATA_W-1:0] i_word,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [1:0]        i_lane,
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  output logic [DATA_W-1:0] o_load,
  output logic [DATA_W-1:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_lane, 3'b000} +: 8];
  assign w_half = i_word[{i_lane[1], 4'b0000} +: 16];

  always_comb begin
    o_load = i_word;
    case (i_size)
      SIZE_BYTE: o_load = i_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SIZE_HALF: o_load = i_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default:   o_load = i_word;
    endcase
  end

  always_comb begin
    o_merged = i_word;
    case (i_size)
      SIZE_BYTE: o_merged[{i_lane, 3'b000} +: 8]     = i_wdata[7:0];
      SIZE_HALF: o_merged[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
      default:   o_merged = i_wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-wide, 1-cycle-read data memory.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_error,
  output logic [DATA_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writeData,
  output logic              mem_MemWrite,
  output logic              mem_MemRead,
  input  logic [DATA_W-1:0] mem_ReadData
);

  typedef enum logic [2:0] {
    IDLE, LD_ADDR, LD_DATA, ST_WR, ST_RD, ST_MERGE, ERR
  } state_t;

  state_t            r_state, w_state_next;
  lsu_req_t          r_req;
  logic              r_resp_valid, r_resp_error;
  logic [DATA_W-1:0] r_resp_rdata;
  logic              w_resp_valid_next, w_resp_error_next;
  logic [DATA_W-1:0] w_resp_rdata_next;
  logic              w_accept, w_illegal;
  logic [DATA_W-1:0] w_mem_index, w_load_data, w_merged;

  assign req_ready   = (r_state == IDLE);
  assign w_accept    = req_ready && req_valid;
  assign w_illegal   = req_illegal(req_addr, req_size, DEPTH);
  assign w_mem_index = {2'b00, r_req.addr[31:2]};
  assign resp_valid  = r_resp_valid;
  assign resp_error  = r_resp_error;
  assign resp_rdata  = r_resp_rdata;

  lsu_lane_align u_align (
    .i_word     (mem_ReadData),
    .i_wdata    (r_req.wdata),
    .i_lane     (r_req.addr[1:0]),
    .i_size     (r_req.size),
    .i_unsigned (r_req.uns),
    .o_load     (w_load_data),
    .o_merged   (w_merged)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  // Memory strobes are decoded from state so a reset drops them immediately.
  always_comb begin
    w_state_next      = r_state;
    w_resp_valid_next = 1'b0;
    w_resp_error_next = 1'b0;
    w_resp_rdata_next = '0;
    mem_MemRead       = 1'b0;
    mem_MemWrite      = 1'b0;
    mem_address       = '0;
    mem_writeData     = '0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_illegal)                  w_state_next = ERR;
          else if (!req_write)            w_state_next = LD_ADDR;
          else if (req_size == SIZE_WORD) w_state_next = ST_WR;
          else                            w_state_next = ST_RD;
        end
      end
      LD_ADDR: begin
        mem_MemRead  = 1'b1;
        mem_address  = w_mem_index;
        w_state_next = LD_DATA;
      end
      LD_DATA: begin
        w_resp_valid_next = 1'b1;
        w_resp_rdata_next = w_load_data;
        w_state_next      = IDLE;
      end
      ST_WR: begin
        mem_MemWrite      = 1'b1;
        mem_address       = w_mem_index;
        mem_writeData     = r_req.wdata;
        w_resp_valid_next = 1'b1;
        w_state_next      = IDLE;
      end
      ST_RD: begin
        mem_MemRead  = 1'b1;
        mem_address  = w_mem_index;
        w_state_next = ST_MERGE;
      end
      ST_MERGE: begin
        mem_MemWrite      = 1'b1;
        mem_address       = w_mem_index;
        mem_writeData     = w_merged;
        w_resp_valid_next = 1'b1;
        w_state_next      = IDLE;
      end
      ERR: begin
        w_resp_valid_next = 1'b1;
        w_resp_error_next = 1'b1;
        w_state_next      = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_req        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_error <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_resp_valid <= w_resp_valid_next;
      r_resp_error <= w_resp_error_next;
      r_resp_rdata <= w_resp_rdata_next;
      if (w_accept) begin
        r_req <= '{size: req_size, uns: req_unsigned, addr: req_addr, wdata: req_wdata};
      end
    end
  end

endmodule
